btc_miner_dispatch: RTL and testbench
=====================================

# btc_miner_dispatch

Nonce-range dispatcher for a multi-core miner. It sits between the register bank and `NUM_CORES` hash cores. It splits a job's nonce range into contiguous per-core sub-ranges, launches the cores, and collects their found-nonce pulses into a result FIFO. It ends the job on exhaustion, on abort, or (in one-shot mode) on the first hit.

## Interface
Parameters:
- `NUM_CORES`, 4: number of hash cores; power of two, 1..16. `IDX_W = max(1, log2(NUM_CORES))`.
- `RES_DEPTH`, 4: result FIFO depth; power of two, 2..16.

Ports:
- `clk`  in  1  single clock.
- `wb_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job start pulse; honoured only in IDLE.
- `abort`  in  1  pulse; stops a running job.
- `nonce_base`  in  32  first nonce of the job.
- `nonce_count`  in  32  number of nonces; 0 means 2^32.
- `cfg_oneshot`  in  1  stop the job after the first accepted result.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at job end.
- `found_any`  out  1  sticky; at least one result was accepted this job.
- `overflow`  out  1  sticky; a result was dropped this job.
- `res_valid`  out  1  FIFO not empty.
- `res_ready`  in  1  consumer pop.
- `res_nonce`  out  32  head nonce.
- `res_core`  out  IDX_W  head core index.
- `core_start`  out  NUM_CORES  per-core one-cycle launch pulse.
- `core_stop`  out  NUM_CORES  per-core one-cycle stop pulse.
- `core_first`  out  NUM_CORES*32  per-core first nonce; core i in bits [32i+31:32i]; held stable while busy.
- `core_last`  out  NUM_CORES*32  per-core last nonce, inclusive.
- `core_done`  in  NUM_CORES  core finished its range or acknowledged stop (pulse).
- `core_found`  in  NUM_CORES  core hit (pulse), qualifying `core_nonce`.
- `core_nonce`  in  NUM_CORES*32  found nonce per core.

## Operation
- FSM states: IDLE, SETUP, LAUNCH, RUN, STOP, FINISH.
- **IDLE → SETUP** on `start`.
  - Clears `found_any` and `overflow`, flushes the FIFO, and latches base and count.
  - Count is held as 33 bits: `total = (nonce_count==0) ? 2^32 : nonce_count`.
- **SETUP** computes the partition with nonce sums taken mod 2^32.
  - `chunk = total >> log2(NUM_CORES)`.
  - Core i: `first = base + i*chunk`, `last = first + chunk - 1`.
  - The last core's `last = base + total - 1`, so it absorbs the remainder.
  - If `total < NUM_CORES`: only core 0 is used, with `first = base` and `last = base+total-1`; the other cores are not started.
- **LAUNCH**:
  - Pulses `core_start` for each used core.
  - Sets `run_mask` to the used cores.
  - Goes to RUN.
- **RUN**:
  - `core_done[i]` clears `run_mask[i]`.
  - `core_found[i]` loads `hold[i] = core_nonce[i]` and sets `hold_v[i]`.
  - If `hold_v[i]` is already set when the new pulse arrives, the new result is dropped and `overflow` is set.
- Arbiter, active in every non-IDLE state:
  - Each cycle, moves the lowest-index valid hold into the FIFO, if the FIFO is not full after this cycle's pop.
  - At most one push per cycle.
  - A full FIFO stalls the holds (backpressure).
- **RUN → STOP** on `abort`, or when `cfg_oneshot` and the first FIFO push occurs.
  - STOP entry pulses `core_stop` for all bits still set in `run_mask`.
- **STOP** waits for `core_done` from the remaining cores.
  - `core_found` is still captured while in STOP.
- **RUN/STOP → FINISH** when `run_mask==0` and `hold_v==0`.
- **FINISH** pulses `done`, drops `busy`, and returns to IDLE.
  - FIFO contents persist until popped or until the next `start`.
- Priorities:
  - `abort` in IDLE is ignored.
  - `start` outside IDLE is ignored.
  - `abort` and a one-shot push in the same cycle: single stop, single STOP entry.
  - `core_done` and `core_found` from the same core in the same cycle: both are processed.
- `wb_rst` in any state:
  - Next cycle is IDLE; FIFO, holds and masks are cleared.
  - No `core_stop` is issued; the cores share `wb_rst`.

## Timing
- Reset values: every output 0, including `core_first`, `core_last` and `res_*`.
- Launch: `start` in cycle T → `busy` from T+1, SETUP in T+1, `core_start` in T+2, RUN from T+3.
- Result path:
  - `core_found` in cycle C → hold valid at C+1 → FIFO push at end of C+1 (if no lower-index hold is valid and the FIFO has room) → `res_valid` at C+2.
  - One cycle per arbitration loss.
- One-shot: first push at end of cycle P → `core_stop` pulse in P+1.
- FIFO handshake:
  - Pop occurs on `res_valid && res_ready`.
  - Simultaneous push and pop when full is allowed.
  - `res_nonce` and `res_core` stay stable while `res_valid && !res_ready`.
- Job end: last `core_done` (and holds empty) in cycle D → `done` in D+2, `busy` low from D+3.

## Test plan
- **Exhaust:** NUM_CORES=4, base=0x0000_0100, count=10 → first/last per core = 0x100/0x101, 0x102/0x103, 0x104/0x105, 0x106/0x109. All done, no found → single `done` pulse, `found_any=0`.
- **Wrap and zero count:** base=0xFFFF_FFFE, count=0 → core0 = 0xFFFF_FFFE/0x3FFF_FFFD, core3 last = 0xFFFF_FFFD.
- **Small job:** count=3 → only `core_start[0]` pulses, core0 range base..base+2.
- **Simultaneous hits:** cores 2 and 1 found in the same cycle, continuous mode → FIFO order core1 then core2, one cycle apart; job ends only after both done.
- **One-shot:** core3 found 0xDEAD_BEEF → `res_core=3`, `res_nonce=0xDEAD_BEEF`, `core_stop` pulsed to still-running cores one cycle after the push, `done` after their `core_done`.
- **Overflow and abort:**
  - `res_ready=0`, RES_DEPTH=2, core0 finds 4 times → 2 results in FIFO, 1 in hold, 1 dropped, `overflow=1`.
  - `abort` → stop pulses, `done`.
  - `wb_rst` mid-RUN → all outputs 0 the next cycle.

Source files
------------

// File: rtl/btc_miner_dispatch.sv
// Nonce-range dispatcher: splits a job's nonce range across NUM_CORES hash cores,
// launches them, and funnels their found-nonce pulses through hold registers into a result FIFO.
module btc_miner_dispatch #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned RES_DEPTH = 4,
  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      wb_rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [31:0]               nonce_base,
  input  logic [31:0]               nonce_count,
  input  logic                      cfg_oneshot,
  output logic                      busy,
  output logic                      done,
  output logic                      found_any,
  output logic                      overflow,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [31:0]               res_nonce,
  output logic [IDX_W-1:0]          res_core,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [NUM_CORES-1:0]      core_stop,
  output logic [NUM_CORES*32-1:0]   core_first,
  output logic [NUM_CORES*32-1:0]   core_last,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [NUM_CORES-1:0]      core_found,
  input  logic [NUM_CORES*32-1:0]   core_nonce
);

  localparam int unsigned LOG2_N = $clog2(NUM_CORES);
  localparam int unsigned PTR_W  = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LAUNCH, S_RUN, S_STOP, S_FINISH
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_base;
  logic [32:0]            r_total;
  logic [NUM_CORES-1:0]   r_run_mask;
  logic [NUM_CORES-1:0]   r_hold_v;
  logic [31:0]            r_hold     [NUM_CORES];
  logic [31:0]            r_mem_nonce[RES_DEPTH];
  logic [IDX_W-1:0]       r_mem_core [RES_DEPTH];
  logic [PTR_W-1:0]       r_wr;
  logic [PTR_W-1:0]       r_rd;
  logic [CNT_W-1:0]       r_cnt;

  logic [31:0]            w_chunk;
  logic                   w_small;
  logic [NUM_CORES-1:0]   w_used;
  logic [NUM_CORES*32-1:0] w_first;
  logic [NUM_CORES*32-1:0] w_last;
  logic                   w_active;
  logic                   w_retire;
  logic                   w_arb_en;
  logic                   w_pop;
  logic                   w_room;
  logic                   w_push;
  logic [IDX_W-1:0]       w_sel;
  logic [NUM_CORES-1:0]   w_cap;
  logic [NUM_CORES-1:0]   w_drop;
  logic [NUM_CORES-1:0]   w_run_nxt;
  logic [PTR_W-1:0]       w_rd_nxt;
  logic [CNT_W-1:0]       w_cnt_after_pop;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_job_clear;

  // Partition of the latched job; all nonce arithmetic wraps mod 2^32.
  always_comb begin
    w_chunk = 32'(r_total >> LOG2_N);
    w_small = (r_total < 33'(NUM_CORES));
    w_used  = w_small ? NUM_CORES'(1) : '1;
    w_first = '0;
    w_last  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_first[32*i +: 32] = r_base + w_chunk * 32'(i);
      w_last[32*i +: 32]  = r_base + w_chunk * 32'(i + 1) - 32'd1;
    end
    // Last core absorbs the remainder of an uneven split.
    w_last[32*(NUM_CORES-1) +: 32] = r_base + r_total[31:0] - 32'd1;
    if (w_small) begin
      w_first        = '0;
      w_last         = '0;
      w_first[31:0]  = r_base;
      w_last[31:0]   = r_base + r_total[31:0] - 32'd1;
    end
  end

  // Lowest-index valid hold wins arbitration.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_hold_v[i]) w_sel = IDX_W'(i);
    end
  end

  assign w_active    = (r_state == S_LAUNCH) || (r_state == S_RUN) || (r_state == S_STOP);
  assign w_retire    = (r_state == S_RUN) || (r_state == S_STOP);
  assign w_arb_en    = (r_state != S_IDLE);
  assign w_pop       = res_valid && res_ready;
  assign w_room      = (r_cnt != CNT_W'(RES_DEPTH)) || w_pop;
  assign w_push      = w_arb_en && (|r_hold_v) && w_room;
  assign w_cap       = core_found & {NUM_CORES{w_active}};
  assign w_drop      = w_cap & r_hold_v;
  assign w_run_nxt   = r_run_mask & ~(core_done & {NUM_CORES{w_retire}});
  assign w_rd_nxt    = r_rd + PTR_W'(w_pop);
  assign w_cnt_after_pop = r_cnt - CNT_W'(w_pop);
  assign w_cnt_nxt   = w_cnt_after_pop + CNT_W'(w_push);
  assign w_job_clear = (r_state == S_IDLE) && start;

  // Job control FSM with registered strobes.
  always_ff @(posedge clk) begin
    if (wb_rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_total    <= '0;
      r_run_mask <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found_any  <= 1'b0;
      overflow   <= 1'b0;
      core_start <= '0;
      core_stop  <= '0;
      core_first <= '0;
      core_last  <= '0;
    end else begin
      done       <= 1'b0;
      core_start <= '0;
      core_stop  <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_SETUP;
            busy       <= 1'b1;
            found_any  <= 1'b0;
            overflow   <= 1'b0;
            r_base     <= nonce_base;
            r_total    <= (nonce_count == 32'd0) ? 33'h1_0000_0000 : {1'b0, nonce_count};
            r_run_mask <= '0;
          end
        end
        S_SETUP: begin
          core_first <= w_first;
          core_last  <= w_last;
          core_start <= w_used;
          r_state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_run_mask <= w_used;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_run_mask <= w_run_nxt;
          if ((r_run_mask == '0) && (r_hold_v == '0)) begin
            r_state <= S_FINISH;
            done    <= 1'b1;
          end else if (abort || (cfg_oneshot && w_push)) begin
            r_state   <= S_STOP;
            core_stop <= w_run_nxt;
          end
        end
        S_STOP: begin
          r_run_mask <= w_run_nxt;
          if ((r_run_mask == '0) && (r_hold_v == '0)) begin
            r_state <= S_FINISH;
            done    <= 1'b1;
          end
        end
        S_FINISH: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_push) found_any <= 1'b1;
      if (|w_drop) overflow <= 1'b1;
    end
  end

  // Per-core hold registers; a pulse arriving on an occupied hold is dropped.
  always_ff @(posedge clk) begin
    if (wb_rst) begin
      r_hold_v <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_push && (w_sel == IDX_W'(i))) r_hold_v[i] <= 1'b0;
        if (w_cap[i] && !r_hold_v[i]) begin
          r_hold_v[i] <= 1'b1;
          r_hold[i]   <= core_nonce[32*i +: 32];
        end
      end
    end
  end

  // Result FIFO with a registered head so res_* never glitch while stalled.
  always_ff @(posedge clk) begin
    if (wb_rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      res_valid <= 1'b0;
      res_nonce <= '0;
      res_core  <= '0;
    end else if (w_job_clear) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      res_valid <= 1'b0;
      res_nonce <= '0;
      res_core  <= '0;
    end else begin
      if (w_push) begin
        r_mem_nonce[r_wr] <= r_hold[w_sel];
        r_mem_core[r_wr]  <= w_sel;
        r_wr              <= r_wr + PTR_W'(1);
      end
      r_rd      <= w_rd_nxt;
      r_cnt     <= w_cnt_nxt;
      res_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        if (w_cnt_after_pop == '0) begin
          res_nonce <= r_hold[w_sel];
          res_core  <= w_sel;
        end else begin
          res_nonce <= r_mem_nonce[w_rd_nxt];
          res_core  <= r_mem_core[w_rd_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_btc_miner_dispatch.sv
// Directed bench for btc_miner_dispatch: scripted core behaviour, results checked through a scoreboard queue.
module tb_btc_miner_dispatch;

  localparam int unsigned NC = 4;
  localparam int unsigned RD = 2;

  logic              clk;
  logic              wb_rst;
  logic              start;
  logic              abort;
  logic [31:0]       nonce_base;
  logic [31:0]       nonce_count;
  logic              cfg_oneshot;
  logic              busy;
  logic              done;
  logic              found_any;
  logic              overflow;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_nonce;
  logic [1:0]        res_core;
  logic [NC-1:0]     core_start;
  logic [NC-1:0]     core_stop;
  logic [NC*32-1:0]  core_first;
  logic [NC*32-1:0]  core_last;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_found;
  logic [NC*32-1:0]  core_nonce;

  int total = 0;
  int bad   = 0;
  logic [33:0] q[$];

  btc_miner_dispatch #(.NUM_CORES(NC), .RES_DEPTH(RD)) dut (
    .clk(clk), .wb_rst(wb_rst), .start(start), .abort(abort),
    .nonce_base(nonce_base), .nonce_count(nonce_count), .cfg_oneshot(cfg_oneshot),
    .busy(busy), .done(done), .found_any(found_any), .overflow(overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_core(res_core),
    .core_start(core_start), .core_stop(core_stop), .core_first(core_first), .core_last(core_last),
    .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_found_any"}, 64'(found_any), 64'd0);
    chk({tag, "_overflow"},  64'(overflow), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_nonce"}, 64'(res_nonce), 64'd0);
    chk({tag, "_res_core"},  64'(res_core), 64'd0);
    chk({tag, "_core_start"}, 64'(core_start), 64'd0);
    chk({tag, "_core_stop"},  64'(core_stop), 64'd0);
    chk({tag, "_core_first"}, 64'(|core_first), 64'd0);
    chk({tag, "_core_last"},  64'(|core_last), 64'd0);
  endtask

  task automatic chk_range(input int idx, input logic [31:0] f, input logic [31:0] l);
    chk($sformatf("first%0d", idx), 64'(core_first[32*idx +: 32]), 64'(f));
    chk($sformatf("last%0d", idx),  64'(core_last[32*idx +: 32]),  64'(l));
  endtask

  task automatic set_nonce(input int idx, input logic [31:0] v);
    core_nonce[32*idx +: 32] = v;
  endtask

  // Compare the FIFO head against the scoreboard front.
  task automatic sb_pop(input string tag);
    logic [33:0] e;
    e = '1;
    if (q.size() != 0) e = q.pop_front();
    chk({tag, "_core"},  64'(res_core),  64'(e[33:32]));
    chk({tag, "_nonce"}, 64'(res_nonce), 64'(e[31:0]));
  endtask

  task automatic pop_check(input string tag);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
    sb_pop(tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Returns in the first RUN cycle of the job.
  task automatic launch(input logic [31:0] b, input logic [31:0] c, input logic os,
                        input logic [3:0] exp_mask);
    nonce_base  = b;
    nonce_count = c;
    cfg_oneshot = os;
    start       = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("setup_no_start", 64'(core_start), 64'd0);
    tick();
    chk("core_start", 64'(core_start), 64'(exp_mask));
    tick();
    chk("core_start_pulse", 64'(core_start), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    tick();
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    wb_rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_oneshot = 1'b0; res_ready = 1'b0;
    nonce_base = '0; nonce_count = '0; core_done = '0; core_found = '0; core_nonce = '0;
    tick();
    tick();
    wb_rst = 1'b0;
    chk_zero("reset");

    // Exhaust: uneven split, exact done/busy timing.
    launch(32'h0000_0100, 32'd10, 1'b0, 4'hF);
    chk_range(0, 32'h100, 32'h101);
    chk_range(1, 32'h102, 32'h103);
    chk_range(2, 32'h104, 32'h105);
    chk_range(3, 32'h106, 32'h109);
    core_done = 4'hF;
    tick();
    core_done = '0;
    chk("exh_done_d1", 64'(done), 64'd0);
    tick();
    chk("exh_done_d2", 64'(done), 64'd1);
    chk("exh_busy_d2", 64'(busy), 64'd1);
    tick();
    chk("exh_done_d3", 64'(done), 64'd0);
    chk("exh_busy_d3", 64'(busy), 64'd0);
    chk("exh_found_any", 64'(found_any), 64'd0);

    // Wrap with count 0 meaning 2^32.
    launch(32'hFFFF_FFFE, 32'd0, 1'b0, 4'hF);
    chk_range(0, 32'hFFFF_FFFE, 32'h3FFF_FFFD);
    chk("wrap_first1", 64'(core_first[63:32]), 64'h3FFF_FFFE);
    chk("wrap_last3", 64'(core_last[127:96]), 64'hFFFF_FFFD);
    core_done = 4'hF;
    tick();
    core_done = '0;
    wait_done("wrap");

    // Small job: only core 0.
    launch(32'h0000_5000, 32'd3, 1'b0, 4'h1);
    chk_range(0, 32'h5000, 32'h5002);
    core_done = 4'h1;
    tick();
    core_done = '0;
    wait_done("small");

    // Simultaneous hits from cores 2 and 1.
    launch(32'h0, 32'h100, 1'b0, 4'hF);
    res_ready  = 1'b1;
    core_found = 4'b0110;
    set_nonce(1, 32'h111);
    set_nonce(2, 32'h222);
    q.push_back({2'd1, 32'h111});
    q.push_back({2'd2, 32'h222});
    tick();
    core_found = '0;
    chk("sim_valid_c1", 64'(res_valid), 64'd0);
    tick();
    chk("sim_valid_c2", 64'(res_valid), 64'd1);
    chk("sim_found_any", 64'(found_any), 64'd1);
    sb_pop("sim_first");
    tick();
    chk("sim_valid_c3", 64'(res_valid), 64'd1);
    sb_pop("sim_second");
    tick();
    chk("sim_valid_c4", 64'(res_valid), 64'd0);
    res_ready = 1'b0;
    core_done = 4'b1011;
    tick();
    core_done = '0;
    tick();
    tick();
    chk("sim_still_busy", 64'(busy), 64'd1);
    chk("sim_no_done", 64'(done), 64'd0);
    core_done = 4'b0100;
    tick();
    core_done = '0;
    wait_done("sim");

    // One-shot: core 0 already finished, core 3 hits.
    launch(32'h1000, 32'h400, 1'b1, 4'hF);
    core_done = 4'b0001;
    tick();
    core_done  = '0;
    core_found = 4'b1000;
    set_nonce(3, 32'hDEAD_BEEF);
    q.push_back({2'd3, 32'hDEAD_BEEF});
    tick();
    core_found = '0;
    chk("os_stop_early", 64'(core_stop), 64'd0);
    tick();
    chk("os_core_stop", 64'(core_stop), 64'b1110);
    chk("os_valid", 64'(res_valid), 64'd1);
    tick();
    chk("os_stop_pulse", 64'(core_stop), 64'd0);
    pop_check("os");
    core_done = 4'b1110;
    tick();
    core_done = '0;
    wait_done("os");

    // Overflow with stalled consumer, then abort.
    launch(32'h2000, 32'h100, 1'b0, 4'hF);
    chk("ovf_found_clr", 64'(found_any), 64'd0);
    chk("ovf_ovf_clr", 64'(overflow), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      core_found = 4'b0001;
      set_nonce(0, 32'h2000 + 32'(k));
      if (k <= 3) q.push_back({2'd0, 32'h2000 + 32'(k)});
      tick();
      core_found = '0;
      tick();
      tick();
    end
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head_stable", 64'(res_nonce), 64'h2001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_stop", 64'(core_stop), 64'hF);
    tick();
    chk("abort_stop_pulse", 64'(core_stop), 64'd0);
    pop_check("ovf_a");
    pop_check("ovf_b");
    pop_check("ovf_c");
    chk("ovf_still_busy", 64'(busy), 64'd1);
    core_done = 4'hF;
    tick();
    core_done = '0;
    wait_done("abort");
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Synchronous reset in the middle of RUN.
    launch(32'h3000, 32'h100, 1'b0, 4'hF);
    core_found = 4'b0010;
    set_nonce(1, 32'h77);
    tick();
    core_found = '0;
    tick();
    tick();
    chk("rst_pre_found", 64'(found_any), 64'd1);
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    chk_zero("midrst");
    q.delete();

    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_stop", 64'(core_stop), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
